// File: rtl/xunit_msched.sv
// xunit_msched: SHA-256 message-schedule generator with a run-triggered start delay.
// A 16-word sliding window streams W[t] on out0; the oldest word leaves at R[0].
module xunit_msched #(
   parameter int unsigned DELAY_W = 10,
   parameter int unsigned DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic [7:0]        delay0,
   input  logic [DATA_W-1:0] in0,
   input  logic [DATA_W-1:0] in1,
   input  logic [DATA_W-1:0] in2,
   input  logic [DATA_W-1:0] in3,
   input  logic [DATA_W-1:0] in4,
   input  logic [DATA_W-1:0] in5,
   input  logic [DATA_W-1:0] in6,
   input  logic [DATA_W-1:0] in7,
   input  logic [DATA_W-1:0] in8,
   input  logic [DATA_W-1:0] in9,
   input  logic [DATA_W-1:0] in10,
   input  logic [DATA_W-1:0] in11,
   input  logic [DATA_W-1:0] in12,
   input  logic [DATA_W-1:0] in13,
   input  logic [DATA_W-1:0] in14,
   input  logic [DATA_W-1:0] in15,
   output logic              done,
   output logic [DATA_W-1:0] out0
);

   localparam int unsigned unused_delay_w = DELAY_W;

   logic [31:0] r_q [16];
   logic [31:0] r_d [16];
   logic [31:0] m   [16];
   logic [7:0]  delay_q;
   logic [7:0]  delay_d;
   logic [31:0] next_w;

   function automatic logic [31:0] sigma0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sigma1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   always_comb begin
      m[0]  = 32'(in0);
      m[1]  = 32'(in1);
      m[2]  = 32'(in2);
      m[3]  = 32'(in3);
      m[4]  = 32'(in4);
      m[5]  = 32'(in5);
      m[6]  = 32'(in6);
      m[7]  = 32'(in7);
      m[8]  = 32'(in8);
      m[9]  = 32'(in9);
      m[10] = 32'(in10);
      m[11] = 32'(in11);
      m[12] = 32'(in12);
      m[13] = 32'(in13);
      m[14] = 32'(in14);
      m[15] = 32'(in15);
   end

   assign next_w = sigma1(r_q[14]) + r_q[9] + sigma0(r_q[1]) + r_q[0];

   // The window keeps shifting while the countdown runs; only run freezes it.
   always_comb begin
      r_d     = r_q;
      delay_d = delay_q;
      if (run) begin
         delay_d = delay0;
      end else begin
         if (delay_q != '0) delay_d = delay_q - 8'd1;
         if (delay_q == 8'd1) begin
            r_d = m;
         end else begin
            for (int unsigned i = 0; i < 15; i++) r_d[i] = r_q[i+1];
            r_d[15] = next_w;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < 16; i++) r_q[i] <= '0;
         delay_q <= '0;
      end else begin
         for (int unsigned i = 0; i < 16; i++) r_q[i] <= r_d[i];
         delay_q <= delay_d;
      end
   end

   assign done = (delay_q == '0);
   assign out0 = DATA_W'(r_q[0]);

endmodule

// File: tb/tb_xunit_msched.sv
// Bench for xunit_msched: schedule-queue reference model checked every cycle,
// plus literal expectations from the SHA-256 "abc" block and timing scenarios.
module tb_xunit_msched;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        run = 1'b0;
   logic [7:0]  delay0 = '0;
   logic [31:0] in_v [16];
   logic        done;
   logic [31:0] out0;

   int checks = 0;
   int errors = 0;

   // Reference: the schedule is a growing list of words; out0 is word t.
   logic [31:0] sched[$];
   int unsigned t;
   int          cnt;

   logic [31:0] held;
   logic [31:0] x0;

   always #5 clk = ~clk;

   xunit_msched #(.DELAY_W(10), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .run(run), .delay0(delay0),
      .in0(in_v[0]),   .in1(in_v[1]),   .in2(in_v[2]),   .in3(in_v[3]),
      .in4(in_v[4]),   .in5(in_v[5]),   .in6(in_v[6]),   .in7(in_v[7]),
      .in8(in_v[8]),   .in9(in_v[9]),   .in10(in_v[10]), .in11(in_v[11]),
      .in12(in_v[12]), .in13(in_v[13]), .in14(in_v[14]), .in15(in_v[15]),
      .done(done), .out0(out0)
   );

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] s0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] s1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic void m_reset();
      sched.delete();
      for (int i = 0; i < 16; i++) sched.push_back(32'h0);
      t   = 0;
      cnt = 0;
   endfunction

   function automatic void m_load();
      sched.delete();
      for (int i = 0; i < 16; i++) sched.push_back(in_v[i]);
      t = 0;
   endfunction

   function automatic void m_advance();
      int n;
      n = sched.size();
      sched.push_back(s1(sched[n-2]) + sched[n-7] + s0(sched[n-15]) + sched[n-16]);
      t++;
      if (t >= 32) begin
         void'(sched.pop_front());
         t--;
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Inputs change at negedge+1, so at the negedge they still show what the
   // preceding rising edge sampled.
   always @(negedge clk) begin
      if (!rst) begin
         m_reset();
      end else if (run) begin
         cnt = int'(delay0);
      end else begin
         if (cnt == 1) m_load();
         else m_advance();
         if (cnt != 0) cnt--;
      end
      chk("out0", out0, sched[t]);
      chk("done", {31'b0, done}, {31'b0, cnt == 0});
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic rand_in();
      for (int i = 0; i < 16; i++) in_v[i] = $urandom;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      rand_in();
      repeat (3) step();
      chk("rst_out0", out0, 32'h0);
      chk("rst_done", {31'b0, done}, 32'h1);
      rst = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         rand_in();
         chk("idle_out0", out0, 32'h0);
         chk("idle_done", {31'b0, done}, 32'h1);
      end

      // SHA-256 "abc" block, delay 1
      for (int i = 0; i < 16; i++) in_v[i] = 32'h0;
      in_v[0]  = 32'h61626380;
      in_v[15] = 32'h00000018;
      delay0 = 8'd1;
      run = 1'b1;
      step();
      run = 1'b0;
      chk("abc_counting", {31'b0, done}, 32'h0);
      step();
      rand_in();
      chk("abc_W0", out0, 32'h61626380);
      repeat (15) begin step(); rand_in(); end
      chk("abc_W15", out0, 32'h00000018);
      step();
      chk("abc_W16", out0, 32'h61626380);
      step();
      chk("abc_W17", out0, 32'h000F0000);
      chk("model_W17", sched[t], 32'h000F0000);
      repeat (46) begin step(); rand_in(); end

      // delay 5 timing
      rand_in();
      x0 = in_v[0];
      delay0 = 8'd5;
      run = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         run = 1'b0;
         chk("d5_done_low", {31'b0, done}, 32'h0);
      end
      step();
      chk("d5_out0", out0, x0);
      chk("d5_done_high", {31'b0, done}, 32'h1);

      // stream 20 words, then delay0 = 0: hold one cycle, keep shifting
      repeat (19) begin step(); rand_in(); end
      held = out0;
      delay0 = 8'd0;
      run = 1'b1;
      step();
      run = 1'b0;
      chk("d0_hold", out0, held);
      repeat (30) begin step(); rand_in(); end

      // restart, stream to word 30, re-pulse with delay 3
      rand_in();
      delay0 = 8'd1;
      run = 1'b1;
      step();
      run = 1'b0;
      step();
      repeat (30) begin step(); rand_in(); end
      held = out0;
      delay0 = 8'd3;
      run = 1'b1;
      step();
      run = 1'b0;
      chk("rerun_hold", out0, held);
      rand_in();
      step();
      rand_in();
      step();
      rand_in();
      x0 = in_v[0];
      step();
      chk("rerun_load", out0, x0);

      // run during the delay==1 cycle suppresses the load
      delay0 = 8'd2;
      run = 1'b1;
      step();
      run = 1'b0;
      step();
      delay0 = 8'd4;
      run = 1'b1;
      step();
      run = 1'b0;
      chk("suppress_counting", {31'b0, done}, 32'h0);
      repeat (10) begin step(); rand_in(); end

      // asynchronous reset mid-stream
      repeat (5) begin step(); rand_in(); end
      #2;
      rst = 1'b0;
      #1;
      chk("async_out0", out0, 32'h0);
      chk("async_done", {31'b0, done}, 32'h1);
      step();
      rst = 1'b1;

      // random blocks, run pulses and delays
      for (int k = 0; k < 600; k++) begin
         step();
         rand_in();
         run = ($urandom_range(0, 29) == 0);
         delay0 = 8'($urandom_range(0, 6));
      end
      step();
      run = 1'b0;
      repeat (3) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
